// File: rtl/pll_config_ctrl_if.sv
// Configuration request bus and PLL pin group for pll_config_ctrl.
// The master side is the register front end plus the PLL model; the slave side is the sequencer.
interface pll_config_ctrl_if;
  logic        CfgValid;
  logic        CfgReady;
  logic [5:0]  CfgClkr;
  logic [12:0] CfgClkf;
  logic [3:0]  CfgClkod;
  logic [11:0] CfgBwadj;
  logic        CfgTest;
  logic        PLLlock;
  logic [5:0]  PLLclkr;
  logic [12:0] PLLclkf;
  logic [3:0]  PLLclkod;
  logic [11:0] PLLbwadj;
  logic        PLLtest;
  logic        PLLfasten;
  logic        PLLconfigdone;
  logic        CfgErr;
  logic        LockLost;

  modport master (
    output CfgValid, CfgClkr, CfgClkf, CfgClkod, CfgBwadj, CfgTest, PLLlock,
    input  CfgReady, PLLclkr, PLLclkf, PLLclkod, PLLbwadj, PLLtest,
           PLLfasten, PLLconfigdone, CfgErr, LockLost
  );

  modport slave (
    input  CfgValid, CfgClkr, CfgClkf, CfgClkod, CfgBwadj, CfgTest, PLLlock,
    output CfgReady, PLLclkr, PLLclkf, PLLclkod, PLLbwadj, PLLtest,
           PLLfasten, PLLconfigdone, CfgErr, LockLost
  );
endinterface

// File: rtl/pll_config_ctrl.sv
// PLL configuration sequencer: accept a divider set, apply it, hold fast-lock through a
// settle interval, wait for a stable synchronized lock, then report done/timeout and
// watch for loss of lock.
// Optional build macro PLL_CFG_RETRY_EN: a lock timeout re-applies the same settings up to
// three times before the sequencer gives up in ERROR.
module pll_config_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_STABLE   = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int CNT_W         = 13
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  pll_config_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] APPLY     = 3'd1;
  localparam logic [2:0] SETTLE    = 3'd2;
  localparam logic [2:0] WAIT_LOCK = 3'd3;
  localparam logic [2:0] LOCKED    = 3'd4;
  localparam logic [2:0] ERROR     = 3'd5;

  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0] STB_LAST    = STB_W'(LOCK_STABLE);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [STB_W-1:0] stb, stb_nxt, stb_inc;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic             lost, lost_nxt;
  logic             ready;
  logic             accept;
  logic [5:0]       clkr;
  logic [12:0]      clkf;
  logic [3:0]       clkod;
  logic [11:0]      bwadj;
  logic             test;
`ifdef PLL_CFG_RETRY_EN
  logic [1:0]       retry, retry_nxt;
`endif

  // Saturating increments: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [STB_W-1:0] stb_sat_inc(input logic [STB_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lock_s = sync_q[1];
  assign ready  = (state == IDLE) || (state == LOCKED) || (state == ERROR);
  assign accept = ready && bus.CfgValid;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], bus.PLLlock};
  end

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stb_nxt   = stb;
    lost_nxt  = lost;
`ifdef PLL_CFG_RETRY_EN
    retry_nxt = retry;
`endif
    cnt_inc   = cnt_sat_inc(cnt);
    stb_inc   = lock_s ? stb_sat_inc(stb) : '0;
    if (accept) begin
      // A new request overrides any lock-loss seen in the same cycle.
      state_nxt = APPLY;
      lost_nxt  = 1'b0;
`ifdef PLL_CFG_RETRY_EN
      retry_nxt = 2'd0;
`endif
    end else begin
      case (state)
        APPLY: begin
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
        SETTLE: begin
          if (cnt_inc == SETTLE_LAST) begin
            cnt_nxt   = '0;
            stb_nxt   = '0;
            state_nxt = WAIT_LOCK;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        WAIT_LOCK: begin
          cnt_nxt = cnt_inc;
          stb_nxt = stb_inc;
          // Lock is tested before timeout so a coincident lock wins.
          if (stb_inc == STB_LAST) begin
            cnt_nxt   = '0;
            stb_nxt   = '0;
            state_nxt = LOCKED;
          end else if (cnt_inc == TMO_LAST) begin
            cnt_nxt = '0;
            stb_nxt = '0;
`ifdef PLL_CFG_RETRY_EN
            if (retry != 2'd3) begin
              retry_nxt = retry + 2'd1;
              state_nxt = APPLY;
            end else begin
              state_nxt = ERROR;
            end
`else
            state_nxt = ERROR;
`endif
          end
        end
        LOCKED: begin
          if (!lock_s) begin
            cnt_nxt   = '0;
            stb_nxt   = '0;
            lost_nxt  = 1'b1;
            state_nxt = WAIT_LOCK;
          end
        end
        IDLE, ERROR: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Sequencer state, counters and sticky lock-lost flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      stb   <= '0;
      lost  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      stb   <= stb_nxt;
      lost  <= lost_nxt;
    end
  end

`ifdef PLL_CFG_RETRY_EN
  // Retry budget for automatic re-apply after a lock timeout.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) retry <= 2'd0;
    else          retry <= retry_nxt;
  end
`endif

  // Applied PLL settings: captured on accept, held through retries and ERROR.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      clkr  <= '0;
      clkf  <= '0;
      clkod <= '0;
      bwadj <= '0;
      test  <= 1'b0;
    end else if (accept) begin
      clkr  <= bus.CfgClkr;
      clkf  <= bus.CfgClkf;
      clkod <= bus.CfgClkod;
      bwadj <= bus.CfgBwadj;
      test  <= bus.CfgTest;
    end
  end

  assign bus.CfgReady      = ready;
  assign bus.PLLclkr       = clkr;
  assign bus.PLLclkf       = clkf;
  assign bus.PLLclkod      = clkod;
  assign bus.PLLbwadj      = bwadj;
  assign bus.PLLtest       = test;
  assign bus.PLLfasten     = (state == APPLY) || (state == SETTLE) || (state == WAIT_LOCK);
  assign bus.PLLconfigdone = (state == LOCKED);
  assign bus.CfgErr        = (state == ERROR);
  assign bus.LockLost      = lost;

endmodule

// File: doc/pll_config_ctrl.md
Name: pll_config_ctrl

Overview:
Sequencer for the on-chip PLL configuration pins (PLLclkr, PLLclkf, PLLclkod, PLLbwadj, PLLfasten, PLLtest, PLLconfigdone) exported by the SoC.
- Accepts a configuration request from the uncore register front end over a valid/ready handshake.
- Applies the request to the PLL, waits a settle interval, then waits for a stable synchronized PLLlock.
- Reports done or timeout, and monitors for loss of lock afterwards.

Parameters:
SETTLE_CYCLES, 64, cycles PLLfasten is held after apply before lock is sampled (≥1)
LOCK_STABLE, 16, consecutive synchronized-lock-high cycles required to declare lock (≥1)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before error (> LOCK_STABLE)
CNT_W, 13, width of shared settle/timeout counter; must hold max(SETTLE_CYCLES, LOCK_TIMEOUT)

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
CfgValid  in  1  config request valid
CfgReady  out  1  config request accepted this cycle when CfgValid&CfgReady
CfgClkr  in  6  requested reference divider
CfgClkf  in  13  requested feedback divider
CfgClkod  in  4  requested output divider
CfgBwadj  in  12  requested bandwidth adjust
CfgTest  in  1  requested PLLtest level
PLLlock  in  1  raw PLL lock, asynchronous to HCLK
PLLclkr  out  6  applied reference divider
PLLclkf  out  13  applied feedback divider
PLLclkod  out  4  applied output divider
PLLbwadj  out  12  applied bandwidth adjust
PLLtest  out  1  applied test level
PLLfasten  out  1  fast-lock enable
PLLconfigdone  out  1  PLL configured and locked
CfgErr  out  1  last sequence timed out
LockLost  out  1  sticky: lock dropped while LOCKED; cleared on next accept

Behaviour:
- Reset, asynchronous, HRESETn=0:
  - State IDLE; counters 0; both synchronizer flops 0.
  - All PLL outputs 0; PLLfasten=0; PLLconfigdone=0; CfgErr=0; LockLost=0; CfgReady=1.
- PLLlock passes through a 2-flop synchronizer to give lock_s. No other use of the raw PLLlock.
- States: IDLE, APPLY, SETTLE, WAIT_LOCK, LOCKED, ERROR.
- CfgReady=1 in IDLE, LOCKED and ERROR; 0 otherwise. Requests presented while busy stall; they are never dropped.
- Accept (CfgValid&CfgReady at edge):
  - Cfg* values are registered onto the PLL outputs at the same edge.
  - PLLconfigdone=0, CfgErr=0, LockLost=0 from the next cycle.
  - Next state is APPLY.
- APPLY: lasts 1 cycle; PLLfasten=1; counter cleared; next state SETTLE.
- SETTLE:
  - PLLfasten=1; counter increments each cycle.
  - After SETTLE_CYCLES cycles: clear the counter and the stable count; next state WAIT_LOCK.
- WAIT_LOCK:
  - PLLfasten=1; timeout counter increments every cycle.
  - Stable count increments when lock_s=1 and clears when lock_s=0.
  - Stable count reaching LOCK_STABLE: next state LOCKED.
  - Otherwise, timeout counter reaching LOCK_TIMEOUT: next state ERROR.
  - If both happen in the same cycle, lock wins.
- LOCKED:
  - PLLconfigdone=1; PLLfasten=0.
  - lock_s=0: PLLconfigdone drops next cycle, LockLost=1, state WAIT_LOCK with counters cleared.
  - If lock_s=0 and an accept occur in the same cycle, the accept wins and LockLost stays 0.
- ERROR: CfgErr=1; PLLconfigdone=0; PLLfasten=0; PLL outputs hold their last values; leave only on accept.
- Latency with PLLlock already high:
  - Accept at edge 0.
  - APPLY in cycle 1.
  - SETTLE in cycles 2..SETTLE_CYCLES+1.
  - WAIT_LOCK in the next LOCK_STABLE cycles.
  - PLLconfigdone=1 from cycle SETTLE_CYCLES+LOCK_STABLE+2, which is 82 with defaults.
- Reset asserted mid-sequence forces the reset values immediately. Sequencing restarts only on a new accept.
- Counters saturate and never wrap.

Optional Feature:
PLL_CFG_RETRY_EN
- Defined:
  - On timeout, the block re-enters APPLY automatically, up to 3 retries; PLL outputs are unchanged.
  - A 2-bit retry count clears on accept.
  - ERROR is entered only after the 4th timeout.
- Not defined: timeout goes directly to ERROR and no retry logic exists.

Test Plan:
- Reset, then accept Clkr=2, Clkf=40, Clkod=1, Bwadj=20 with PLLlock tied 1 → outputs updated next cycle; PLLfasten=1 during cycles 1..81; PLLconfigdone=1 from cycle 82; CfgErr=0.
- PLLlock toggling 1/0 every 10 cycles during WAIT_LOCK → stable count never reaches 16; exactly 4096 WAIT_LOCK cycles, then CfgErr=1, PLLconfigdone=0, CfgReady=1. With PLL_CFG_RETRY_EN, this happens only after the 4th timeout.
- LOCKED, then PLLlock drops 1 cycle → PLLconfigdone=0 and LockLost=1 3 cycles later (2 sync + 1 register); relocks after 16 stable cycles; LockLost stays 1.
- Hold CfgValid with new values during SETTLE → CfgReady=0 and outputs unchanged until LOCKED; accepted on the first LOCKED cycle; PLLconfigdone drops next cycle.
- HRESETn pulsed low in WAIT_LOCK → all outputs 0 asynchronously; IDLE after release; no activity without CfgValid.
- In LOCKED, lock_s falls and CfgValid is accepted in the same cycle → state APPLY; LockLost=0.
